// File: rtl/sonar_varredura_n_pkg.sv
// Shared constants for the sonar sweep controller and its frame formatter.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package sonar_varredura_n_pkg;

  // FSM encoding, also exported on db_estado
  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_ESPERA     = 4'd1;
  localparam logic [3:0] ST_MEDE       = 4'd2;
  localparam logic [3:0] ST_AGUARDA    = 4'd3;
  localparam logic [3:0] ST_TRANSMITE  = 4'd4;
  localparam logic [3:0] ST_AGUARDA_TX = 4'd5;
  localparam logic [3:0] ST_PROXIMO    = 4'd6;

  // 7-bit ASCII characters used in the "AAA,D..D#" record
  localparam logic [6:0] ASCII_ZERO    = 7'h30;
  localparam logic [6:0] ASCII_VIRGULA = 7'h2C;
  localparam logic [6:0] ASCII_HASH    = 7'h23;
  localparam logic [6:0] ASCII_TRACO   = 7'h2D;

  // One distance digit: '-' when the echo timed out, otherwise '0'+nibble.
  // Nibbles above 9 pass straight through to 0x3A..0x3F.
  function automatic logic [6:0] digito_ascii(input logic [3:0] bcd, input logic sem_eco);
    return sem_eco ? ASCII_TRACO : (ASCII_ZERO + {3'b000, bcd});
  endfunction

endpackage

// File: rtl/sonar_frame_mux_n.sv
// Character selector for one sonar record: angle(3) ',' digits(DIGITS) '#'.
// Latency: combinational.
// Backpressure: none; the caller holds idx until the transmitter accepts the char.
// Ports: idx (character index), angulo_ascii (3 angle chars, [20:14] first),
//        distancia (latched BCD), timeout (dash the digits), caractere (ASCII out).
module sonar_frame_mux_n
  import sonar_varredura_n_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int IDX_W  = $clog2(DIGITS + 5)
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic [20:0]         angulo_ascii,
  input  logic [4*DIGITS-1:0] distancia,
  input  logic                timeout,
  output logic [6:0]          caractere
);

  always_comb begin
    caractere = ASCII_HASH;
    if (idx == IDX_W'(0)) begin
      caractere = angulo_ascii[20:14];
    end else if (idx == IDX_W'(1)) begin
      caractere = angulo_ascii[13:7];
    end else if (idx == IDX_W'(2)) begin
      caractere = angulo_ascii[6:0];
    end else if (idx == IDX_W'(3)) begin
      caractere = ASCII_VIRGULA;
    end else begin
      // digits go out most significant nibble first
      for (int k = 0; k < DIGITS; k++) begin
        if (idx == IDX_W'(4 + k)) begin
          caractere = digito_ascii(distancia[4*(DIGITS-1-k) +: 4], timeout);
        end
      end
    end
  end

endmodule

// File: rtl/sonar_varredura_n.sv
// Sonar sweep controller: dwell, trigger one measurement, stream the ASCII record, step servo.
// Latency: T_DWELL + echo wait (<= T_TIMEOUT) + DIGITS+5 transmitter round trips per position.
// Backpressure: one char in flight; next tx_partida only after tx_pronto of the previous char.
// Ports: clock/reset (async, active-low), ligar/modo control, medir/pronto_medida/medida sensor
//        handshake, angulo_ascii from the angle ROM at posicao, tx_* serial transmitter handshake,
//        fim_frame/timeout status, db_estado FSM state.
module sonar_varredura_n
  import sonar_varredura_n_pkg::*;
#(
  parameter int N_POS     = 8,
  parameter int POS_W     = 3,
  parameter int DIGITS    = 3,
  parameter int T_DWELL   = 100_000_000,
  parameter int T_TIMEOUT = 10_000_000,
  parameter int CW        = 27
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar,
  input  logic                modo,
  output logic                medir,
  input  logic                pronto_medida,
  input  logic [4*DIGITS-1:0] medida,
  input  logic [20:0]         angulo_ascii,
  output logic [POS_W-1:0]    posicao,
  output logic                tx_partida,
  output logic [6:0]          tx_dados,
  input  logic                tx_pronto,
  output logic                fim_frame,
  output logic                timeout,
  output logic [3:0]          db_estado
);

  localparam int IDX_W = $clog2(DIGITS + 5);
  localparam logic [IDX_W-1:0] IDX_ULT   = IDX_W'(DIGITS + 4);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(N_POS - 1);
  localparam logic [CW-1:0]    CNT_DWELL = CW'(T_DWELL - 1);
  localparam logic [CW-1:0]    CNT_TMO   = CW'(T_TIMEOUT - 1);

  logic [3:0]          estado;
  logic [CW-1:0]       cnt;       // shared by dwell and echo-timeout waits
  logic [IDX_W-1:0]    idx;
  logic                sobe;      // ping-pong direction, 1 = increasing
  logic [4*DIGITS-1:0] distancia;
  logic [6:0]          caractere;

  sonar_frame_mux_n #(
    .DIGITS (DIGITS),
    .IDX_W  (IDX_W)
  ) u_frame_mux (
    .idx          (idx),
    .angulo_ascii (angulo_ascii),
    .distancia    (distancia),
    .timeout      (timeout),
    .caractere    (caractere)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      posicao   <= '0;
      sobe      <= 1'b1;
      distancia <= '0;
      timeout   <= 1'b0;
    end else begin
      case (estado)
        ST_IDLE: begin
          if (ligar) begin
            estado <= ST_ESPERA;
            cnt    <= '0;
          end
        end
        ST_ESPERA: begin
          if (cnt == CNT_DWELL) begin
            estado  <= ST_MEDE;
            timeout <= 1'b0;  // flag stays valid through PROXIMO, drops entering MEDE
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_MEDE: begin
          cnt    <= '0;
          idx    <= '0;
          estado <= ST_AGUARDA;
        end
        ST_AGUARDA: begin
          // a completion on the expiry cycle still counts as a valid echo
          if (pronto_medida) begin
            distancia <= medida;
            timeout   <= 1'b0;
            estado    <= ST_TRANSMITE;
          end else if (cnt == CNT_TMO) begin
            timeout <= 1'b1;
            estado  <= ST_TRANSMITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TRANSMITE: begin
          estado <= ST_AGUARDA_TX;
        end
        ST_AGUARDA_TX: begin
          if (tx_pronto) begin
            if (idx == IDX_ULT) begin
              estado <= ST_PROXIMO;
            end else begin
              idx    <= idx + 1'b1;
              estado <= ST_TRANSMITE;
            end
          end
        end
        ST_PROXIMO: begin
          if (N_POS == 1) begin
            posicao <= '0;
          end else if (!modo) begin
            if (posicao == POS_MAX) begin
              posicao <= '0;
              sobe    <= 1'b1;
            end else begin
              posicao <= posicao + 1'b1;
            end
          end else if (sobe) begin
            if (posicao == POS_MAX) begin
              sobe    <= 1'b0;
              posicao <= posicao - 1'b1;
            end else begin
              posicao <= posicao + 1'b1;
            end
          end else begin
            if (posicao == '0) begin
              sobe    <= 1'b1;
              posicao <= posicao + 1'b1;
            end else begin
              posicao <= posicao - 1'b1;
            end
          end
          cnt    <= '0;
          estado <= ligar ? ST_ESPERA : ST_IDLE;
        end
        default: begin
          estado <= ST_IDLE;
        end
      endcase
    end
  end

  assign medir      = (estado == ST_MEDE);
  assign tx_partida = (estado == ST_TRANSMITE);
  assign fim_frame  = (estado == ST_PROXIMO);
  assign db_estado  = estado;
  // char is held for the whole transmit handshake, zero otherwise
  assign tx_dados   = ((estado == ST_TRANSMITE) || (estado == ST_AGUARDA_TX)) ? caractere : 7'h00;

endmodule
